// File: rtl/factor_checker.sv
// Consumer of factorFinder results: captures product/factors on a rising isDone,
// recomputes factorA*factorB with a sequential shift-add multiplier and flags validity/triviality.
module factor_checker #(
  parameter int unsigned FACTOR_W  = 16,
  parameter int unsigned PRODUCT_W = 2 * FACTOR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PRODUCT_W-1:0] product,
  input  logic [FACTOR_W-1:0]  factorA,
  input  logic [FACTOR_W-1:0]  factorB,
  input  logic                 isDone,
  output logic                 busy,
  output logic                 checkDone,
  output logic                 isValid,
  output logic                 isTrivial,
  output logic [PRODUCT_W-1:0] calcProduct
);

  localparam int unsigned STEP_W = $clog2(FACTOR_W + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(FACTOR_W - 1);

  typedef enum logic [1:0] {
    stIdle = 2'd0,
    stMult = 2'd1,
    stCmp  = 2'd2
  } state_t;

  state_t state;
  state_t stateNxt;

  logic isDoneQ;
  logic startEvt;

  logic [PRODUCT_W-1:0] prodLat,  prodLatNxt;
  logic [PRODUCT_W-1:0] mcand,    mcandNxt;
  logic [FACTOR_W-1:0]  mplier,   mplierNxt;
  logic [PRODUCT_W-1:0] acc,      accNxt;
  logic [STEP_W-1:0]    step,     stepNxt;
  logic                 trivLat,  trivLatNxt;
  logic                 busyNxt;
  logic                 checkDoneNxt;
  logic                 isValidNxt;
  logic                 isTrivialNxt;
  logic [PRODUCT_W-1:0] calcProductNxt;

  // A new result is a rising edge of the level-held isDone.
  assign startEvt = isDone && !isDoneQ;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= stIdle;
    else        state <= stateNxt;
  end

  // Next-state logic
  always_comb begin
    stateNxt = state;
    case (state)
      stIdle:  if (startEvt) stateNxt = stMult;
      stMult:  if (step == LAST_STEP) stateNxt = stCmp;
      stCmp:   stateNxt = stIdle;
      default: stateNxt = stIdle;
    endcase
  end

  // Output/datapath next values; everything holds unless the state acts on it.
  always_comb begin
    prodLatNxt     = prodLat;
    mcandNxt       = mcand;
    mplierNxt      = mplier;
    accNxt         = acc;
    stepNxt        = step;
    trivLatNxt     = trivLat;
    busyNxt        = busy;
    checkDoneNxt   = checkDone;
    isValidNxt     = isValid;
    isTrivialNxt   = isTrivial;
    calcProductNxt = calcProduct;
    case (state)
      stIdle: begin
        if (startEvt) begin
          prodLatNxt   = product;
          mcandNxt     = PRODUCT_W'(factorA);
          mplierNxt    = factorB;
          trivLatNxt   = (factorA <= FACTOR_W'(1)) || (factorB <= FACTOR_W'(1));
          accNxt       = '0;
          stepNxt      = '0;
          checkDoneNxt = 1'b0;
          busyNxt      = 1'b1;
        end
      end
      stMult: begin
        if (mplier[0]) accNxt = acc + mcand;
        mcandNxt  = mcand << 1;
        mplierNxt = mplier >> 1;
        stepNxt   = step + STEP_W'(1);
      end
      stCmp: begin
        calcProductNxt = acc;
        isValidNxt     = (acc == prodLat);
        isTrivialNxt   = trivLat;
        checkDoneNxt   = 1'b1;
        busyNxt        = 1'b0;
      end
      default: begin
        busyNxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; isDoneQ tracks isDone in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isDoneQ     <= 1'b0;
      prodLat     <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      step        <= '0;
      trivLat     <= 1'b0;
      busy        <= 1'b0;
      checkDone   <= 1'b0;
      isValid     <= 1'b0;
      isTrivial   <= 1'b0;
      calcProduct <= '0;
    end else begin
      isDoneQ     <= isDone;
      prodLat     <= prodLatNxt;
      mcand       <= mcandNxt;
      mplier      <= mplierNxt;
      acc         <= accNxt;
      step        <= stepNxt;
      trivLat     <= trivLatNxt;
      busy        <= busyNxt;
      checkDone   <= checkDoneNxt;
      isValid     <= isValidNxt;
      isTrivial   <= isTrivialNxt;
      calcProduct <= calcProductNxt;
    end
  end

endmodule

// File: tb/tb_factor_checker.sv
// Self-checking bench for factor_checker: directed cases plus randomized results
// compared against a plain-arithmetic reference model.
module tb_factor_checker;

  logic        clk;
  logic        rst_n;
  logic [31:0] product;
  logic [15:0] factorA;
  logic [15:0] factorB;
  logic        isDone;
  logic        busy;
  logic        checkDone;
  logic        isValid;
  logic        isTrivial;
  logic [31:0] calcProduct;

  int checks;
  int errors;
  int doneRises = 0;
  logic cdPrev = 1'b0;

  factor_checker #(.FACTOR_W(16), .PRODUCT_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .product(product),
    .factorA(factorA),
    .factorB(factorB),
    .isDone(isDone),
    .busy(busy),
    .checkDone(checkDone),
    .isValid(isValid),
    .isTrivial(isTrivial),
    .calcProduct(calcProduct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts completed checks as rising edges of checkDone.
  always @(negedge clk) begin
    if (checkDone && !cdPrev) doneRises <= doneRises + 1;
    cdPrev <= checkDone;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".checkDone"}, 32'(checkDone), 32'd0);
    check({tag, ".isValid"}, 32'(isValid), 32'd0);
    check({tag, ".isTrivial"}, 32'(isTrivial), 32'd0);
    check({tag, ".calcProduct"}, calcProduct, 32'd0);
  endtask

  // Caller arranges that the next posedge is the capturing edge.
  task automatic waitResult(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] p);
    logic [31:0] expProd;
    logic        expValid;
    logic        expTriv;
    logic        winOk;
    expProd  = 32'(a) * 32'(b);
    expValid = (expProd == p);
    expTriv  = (a < 16'd2) || (b < 16'd2);
    @(posedge clk); #1;
    check({tag, ".capBusy"}, 32'(busy), 32'd1);
    check({tag, ".capDoneClr"}, 32'(checkDone), 32'd0);
    winOk = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1 || checkDone !== 1'b0) winOk = 1'b0;
    end
    check({tag, ".busyWindow"}, 32'(winOk), 32'd1);
    @(posedge clk); #1;
    check({tag, ".checkDone"}, 32'(checkDone), 32'd1);
    check({tag, ".busyLow"}, 32'(busy), 32'd0);
    check({tag, ".calcProduct"}, calcProduct, expProd);
    check({tag, ".isValid"}, 32'(isValid), 32'(expValid));
    check({tag, ".isTrivial"}, 32'(isTrivial), 32'(expTriv));
  endtask

  task automatic runCheck(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] p);
    @(negedge clk);
    factorA = a;
    factorB = b;
    product = p;
    isDone  = 1'b1;
    waitResult(tag, a, b, p);
    @(negedge clk);
    isDone = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] rp;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    isDone  = 1'b0;
    factorA = '0;
    factorB = '0;
    product = '0;
    repeat (3) @(negedge clk);
    checkIdleZero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idleNoStart.checkDone", 32'(checkDone), 32'd0);

    runCheck("t1", 16'd13, 16'd17, 32'd221);
    runCheck("t2", 16'd3, 16'd7, 32'd15);
    runCheck("t3", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    runCheck("t4a", 16'd1, 16'd97, 32'd97);
    runCheck("t4b", 16'd0, 16'd5, 32'd0);
    runCheck("zeroBadProd", 16'd0, 16'd9, 32'd4);

    // Held isDone yields a single check; a re-pulse while busy is ignored.
    @(negedge clk);
    base = doneRises;
    factorA = 16'd6; factorB = 16'd7; product = 32'd42; isDone = 1'b1;
    repeat (100) @(negedge clk);
    check("hold.rises", 32'(doneRises - base), 32'd1);
    check("hold.calc", calcProduct, 32'd42);
    isDone = 1'b0;
    @(negedge clk);
    factorA = 16'd10; factorB = 16'd10; product = 32'd100; isDone = 1'b1;
    repeat (5) @(negedge clk);
    isDone = 1'b0;
    factorA = 16'd3; factorB = 16'd3; product = 32'd1;
    @(negedge clk);
    isDone = 1'b1;
    repeat (40) @(negedge clk);
    check("repulse.rises", 32'(doneRises - base), 32'd2);
    check("repulse.calc", calcProduct, 32'd100);
    check("repulse.isValid", 32'(isValid), 32'd1);
    check("repulse.busy", 32'(busy), 32'd0);
    isDone = 1'b0;
    @(negedge clk);

    // Reset mid-multiply, then isDone already high at release starts a check.
    factorA = 16'd9; factorB = 16'd9; product = 32'd81; isDone = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkIdleZero("midReset");
    factorA = 16'd5; factorB = 16'd11; product = 32'd55;
    @(negedge clk);
    rst_n = 1'b1;
    waitResult("afterReset", 16'd5, 16'd11, 32'd55);
    @(negedge clk);
    isDone = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 16'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 2));
      case ($urandom_range(0, 2))
        0:       rp = 32'(ra) * 32'(rb);
        1:       rp = $urandom;
        default: rp = (32'(ra) * 32'(rb)) ^ (32'd1 << $urandom_range(0, 31));
      endcase
      runCheck("rand", ra, rb, rp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
